// File: rtl/md_unit_ctrl.sv
// HI/LO multiply/divide sequencer for the EX stage. The result is computed when
// start is accepted, held internally, and committed after a fixed busy count.
module md_unit_ctrl #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    localparam logic [3:0] MUL_LD = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_LD = 4'(DIV_CYCLES);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic        div0_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [63:0] res_q;
    logic [63:0] res_d;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               div_sgn;
    logic        [31:0] dvd_mag;
    logic        [31:0] dvs_mag;
    logic        [31:0] q_mag;
    logic        [31:0] r_mag;
    logic        [31:0] quot;
    logic        [31:0] rem;

    assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign prod_u = {32'b0, rs_val} * {32'b0, rt_val};

    // Signed divide works on magnitudes; INT_MIN / -1 then wraps back to INT_MIN with rem 0.
    assign div_sgn = ~md_op[0];
    assign dvd_mag = (div_sgn && rs_val[31]) ? 32'(-rs_val) : rs_val;
    assign dvs_mag = (div_sgn && rt_val[31]) ? 32'(-rt_val) : rt_val;
    assign q_mag   = (dvs_mag == '0) ? '0 : dvd_mag / dvs_mag;
    assign r_mag   = (dvs_mag == '0) ? '0 : dvd_mag % dvs_mag;
    assign quot    = (div_sgn && (rs_val[31] ^ rt_val[31])) ? 32'(-q_mag) : q_mag;
    assign rem     = (div_sgn && rs_val[31]) ? 32'(-r_mag) : r_mag;

    always_comb begin
        res_d = '0;
        unique case (md_op)
            2'b00:   res_d = prod_s;
            2'b01:   res_d = prod_u;
            default: res_d = {rem, quot};
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            div0_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        res_q   <= res_d;
                        div0_q  <= md_op[1] && (rt_val == '0);
                        cnt_q   <= md_op[1] ? DIV_LD : MUL_LD;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        if (wr_hi) hi_q <= rs_val;
                        if (wr_lo) lo_q <= rs_val;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                        if (!div0_q) begin
                            hi_q <= res_q[63:32];
                            lo_q <= res_q[31:0];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign md_stall = start | busy_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl: reset, mult/div results, latency, busy
// protection, back-to-back starts and the stall request.
module tb_md_unit_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  md_op;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    md_unit_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .wr_hi    (wr_hi),
        .wr_lo    (wr_lo),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation and count the cycles busy stays high (bounded).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        md_op = op; rs_val = a; rt_val = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (hi !== 32'h0)   begin errors++; $display("FAIL reset_hi got %h exp 0", hi); end
        checks++; if (lo !== 32'h0)   begin errors++; $display("FAIL reset_lo got %h exp 0", lo); end
        checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", md_stall); end
    endtask

    task automatic test_mult;
        int n;
        run_op(2'b00, 32'hFFFF_FFFE, 32'd3, n);
        checks++; if (n !== 5) begin errors++; $display("FAIL mult_cycles got %0d exp 5", n); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got %h exp fffffffa", lo); end
        run_op(2'b01, 32'hFFFF_FFFE, 32'd3, n);
        checks++; if (n !== 5) begin errors++; $display("FAIL multu_cycles got %0d exp 5", n); end
        checks++; if (hi !== 32'h0000_0002) begin errors++; $display("FAIL multu_hi got %h exp 00000002", hi); end
        checks++; if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL multu_lo got %h exp fffffffa", lo); end
    endtask

    task automatic test_div;
        int n;
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, n);
        checks++; if (n !== 10) begin errors++; $display("FAIL div_cycles got %0d exp 10", n); end
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h exp fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h exp ffffffff", hi); end
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, n);
        checks++; if (n !== 10) begin errors++; $display("FAIL divu_cycles got %0d exp 10", n); end
        checks++; if (lo !== 32'h7FFF_FFFC) begin errors++; $display("FAIL divu_lo got %h exp 7ffffffc", lo); end
        checks++; if (hi !== 32'h0000_0001) begin errors++; $display("FAIL divu_hi got %h exp 00000001", hi); end
        // 7 / -2: quotient -3, remainder +1 (sign of dividend)
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, n);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_negdvs_lo got %h exp fffffffd", lo); end
        checks++; if (hi !== 32'h0000_0001) begin errors++; $display("FAIL div_negdvs_hi got %h exp 00000001", hi); end
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, n);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got %h exp 80000000", lo); end
        checks++; if (hi !== 32'h0000_0000) begin errors++; $display("FAIL div_ovf_hi got %h exp 00000000", hi); end
    endtask

    task automatic test_mthi_mtlo;
        int n;
        wr_hi = 1'b1; rs_val = 32'h0000_0011;
        @(posedge clk); #1;
        wr_hi = 1'b0;
        checks++; if (hi !== 32'h0000_0011) begin errors++; $display("FAIL mthi got %h exp 00000011", hi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b exp 0", busy); end
        wr_lo = 1'b1; rs_val = 32'h0000_0022;
        @(posedge clk); #1;
        wr_lo = 1'b0;
        checks++; if (lo !== 32'h0000_0022) begin errors++; $display("FAIL mtlo got %h exp 00000022", lo); end
        checks++; if (hi !== 32'h0000_0011) begin errors++; $display("FAIL mtlo_hi_kept got %h exp 00000011", hi); end
        wr_hi = 1'b1; wr_lo = 1'b1; rs_val = 32'h0000_0033;
        @(posedge clk); #1;
        wr_hi = 1'b0; wr_lo = 1'b0;
        checks++; if (hi !== 32'h0000_0033) begin errors++; $display("FAIL mtboth_hi got %h exp 00000033", hi); end
        checks++; if (lo !== 32'h0000_0033) begin errors++; $display("FAIL mtboth_lo got %h exp 00000033", lo); end
        // start together with mthi: start wins, hi stays 0x33 while busy
        wr_hi = 1'b1; md_op = 2'b00; rs_val = 32'd2; rt_val = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        wr_hi = 1'b0; start = 1'b0;
        checks++; if (hi !== 32'h0000_0033) begin errors++; $display("FAIL start_wins_hi got %h exp 00000033", hi); end
        n = 0;
        while (busy === 1'b1 && n < 40) begin n++; @(posedge clk); #1; end
        checks++; if (lo !== 32'd6) begin errors++; $display("FAIL start_wins_lo got %h exp 00000006", lo); end
    endtask

    task automatic test_div0;
        int n;
        wr_hi = 1'b1; rs_val = 32'h11;
        @(posedge clk); #1;
        wr_hi = 1'b0; wr_lo = 1'b1; rs_val = 32'h22;
        @(posedge clk); #1;
        wr_lo = 1'b0;
        run_op(2'b10, 32'd5, 32'd0, n);
        checks++; if (n !== 10) begin errors++; $display("FAIL div0_cycles got %0d exp 10", n); end
        checks++; if (hi !== 32'h11) begin errors++; $display("FAIL div0_hi got %h exp 00000011", hi); end
        checks++; if (lo !== 32'h22) begin errors++; $display("FAIL div0_lo got %h exp 00000022", lo); end
    endtask

    task automatic test_busy_protect;
        int n;
        md_op = 2'b00; rs_val = 32'd3; rt_val = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        wr_lo = 1'b1; start = 1'b1; md_op = 2'b10; rs_val = 32'hDEAD; rt_val = 32'd1;
        @(posedge clk); #1;
        wr_lo = 1'b0; start = 1'b0;
        checks++; if (lo !== 32'h22) begin errors++; $display("FAIL protect_lo_busy got %h exp 00000022", lo); end
        while (busy === 1'b1 && n < 40) begin n++; @(posedge clk); #1; end
        checks++; if (n !== 5) begin errors++; $display("FAIL protect_cycles got %0d exp 5", n); end
        checks++; if (lo !== 32'd12) begin errors++; $display("FAIL protect_lo got %h exp 0000000c", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL protect_hi got %h exp 00000000", hi); end
    endtask

    task automatic test_back_to_back;
        int n;
        md_op = 2'b00; rs_val = 32'd2; rt_val = 32'd3; start = 1'b1;
        #1;
        checks++; if (md_stall !== 1'b1) begin errors++; $display("FAIL b2b_stall_start got %b exp 1", md_stall); end
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            checks++; if (md_stall !== 1'b1) begin errors++; $display("FAIL b2b_stall_busy got %b exp 1", md_stall); end
            @(posedge clk); #1;
        end
        checks++; if (n !== 5) begin errors++; $display("FAIL b2b_mult_cycles got %0d exp 5", n); end
        checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL b2b_stall_idle got %b exp 0", md_stall); end
        checks++; if (lo !== 32'd6) begin errors++; $display("FAIL b2b_mult_lo got %h exp 00000006", lo); end
        md_op = 2'b11; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
        #1;
        checks++; if (md_stall !== 1'b1) begin errors++; $display("FAIL b2b_stall_start2 got %b exp 1", md_stall); end
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got %b exp 1", busy); end
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            checks++; if (md_stall !== 1'b1) begin errors++; $display("FAIL b2b_stall_busy2 got %b exp 1", md_stall); end
            @(posedge clk); #1;
        end
        checks++; if (n !== 10) begin errors++; $display("FAIL b2b_divu_cycles got %0d exp 10", n); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL b2b_divu_lo got %h exp 0000000e", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL b2b_divu_hi got %h exp 00000002", hi); end
        checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL b2b_stall_end got %b exp 0", md_stall); end
    endtask

    task automatic test_reset_midop;
        md_op = 2'b00; rs_val = 32'd3; rt_val = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before got %b exp 1", busy); end
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL rmid_hi got %h exp 00000000", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL rmid_lo got %h exp 00000000", lo); end
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy_after got %b exp 0", busy); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL rmid_hi_after got %h exp 00000000", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL rmid_lo_after got %h exp 00000000", lo); end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; md_op = 2'b00; wr_hi = 1'b0; wr_lo = 1'b0;
        rs_val = '0; rt_val = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_div0();
        test_busy_protect();
        test_back_to_back();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
